// File: rtl/fsm_ctrl_param.sv
// Configuration/monitor controller for a bank of FIFOs: commits threshold pairs,
// tracks idle/active activity and latches FIFO error sources until reconfigured.
module fsm_ctrl_param #(
    parameter int N_FIFOS  = 8,
    parameter int TH_W     = 3,
    parameter int IDLE_DLY = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [TH_W-1:0]    bajo,
    input  logic [TH_W-1:0]    alto,
    input  logic [N_FIFOS-1:0] empty_fifos,
    input  logic [N_FIFOS-1:0] error_fifos,
    output logic [2:0]         estado_actual,
    output logic [2:0]         sig_estado,
    output logic [TH_W-1:0]    bajo_out,
    output logic [TH_W-1:0]    alto_out,
    output logic               idle_out,
    output logic               active_out,
    output logic               error_out,
    output logic               config_err,
    output logic [N_FIFOS-1:0] error_src
);

    localparam int CNT_W = $clog2(IDLE_DLY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_DLY);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [TH_W-1:0]   shadow_bajo;
    logic [TH_W-1:0]   shadow_alto;
    logic [CNT_W-1:0]  empty_cnt;
    logic              all_empty;
    logic              any_err;
    logic              cfg_ok;

    assign all_empty     = &empty_fifos;
    assign any_err       = |error_fifos;
    assign cfg_ok        = shadow_bajo < shadow_alto;
    assign estado_actual = state_q;
    assign sig_estado    = state_d;

    // Errors outrank reconfiguration, which outranks the activity rules.
    always_comb begin
        state_d = ST_RESET;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (init)        state_d = ST_INIT;
                else if (cfg_ok) state_d = ST_IDLE;
                else             state_d = ST_ERROR;
            end
            ST_IDLE: begin
                if (any_err)        state_d = ST_ERROR;
                else if (init)      state_d = ST_INIT;
                else if (all_empty) state_d = ST_IDLE;
                else                state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_err)                                state_d = ST_ERROR;
                else if (init)                              state_d = ST_INIT;
                else if (all_empty && empty_cnt == CNT_LAST) state_d = ST_IDLE;
                else                                        state_d = ST_ACTIVE;
            end
            ST_ERROR: begin
                if (init) state_d = ST_INIT;
                else      state_d = ST_ERROR;
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_out   <= (state_d == ST_IDLE);
            active_out <= (state_d == ST_ACTIVE);
            error_out  <= (state_d == ST_ERROR);
        end
    end

    // The run counter only lives while staying in ACTIVE; any exit leaves it at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            empty_cnt <= '0;
        end else if (state_q == ST_ACTIVE && state_d == ST_ACTIVE && all_empty) begin
            if (empty_cnt != CNT_MAX) empty_cnt <= empty_cnt + 1'b1;
        end else begin
            empty_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_bajo <= '0;
            shadow_alto <= '0;
            bajo_out    <= '0;
            alto_out    <= '0;
            config_err  <= 1'b0;
        end else if (state_q == ST_INIT) begin
            if (init) begin
                shadow_bajo <= bajo;
                shadow_alto <= alto;
            end else if (cfg_ok) begin
                bajo_out <= shadow_bajo;
                alto_out <= shadow_alto;
            end else begin
                config_err <= 1'b1;
            end
        end else if (state_q == ST_ERROR && init) begin
            config_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_src <= '0;
        end else if ((state_q == ST_IDLE || state_q == ST_ACTIVE) && any_err) begin
            error_src <= error_src | error_fifos;
        end else if (state_q == ST_ERROR && init) begin
            error_src <= '0;
        end
    end

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// Bench for fsm_ctrl_param: two instances (8 FIFOs/delay 4 and 4 FIFOs/delay 1)
// driven in lockstep and compared every cycle against a rule-level model.
module tb_fsm_ctrl_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [2:0] bajo, alto;
    logic [7:0] empty, err;

    logic [2:0] d0_estado, d0_sig, d0_bout, d0_aout;
    logic       d0_idle, d0_act, d0_errout, d0_cfg;
    logic [7:0] d0_esrc;
    logic [2:0] d1_estado, d1_sig, d1_bout, d1_aout;
    logic       d1_idle, d1_act, d1_errout, d1_cfg;
    logic [3:0] d1_esrc;

    int n_checks = 0;
    int n_fail   = 0;

    int         m_nf[2]  = '{8, 4};
    int         m_dly[2] = '{4, 1};
    int         m_st[2], m_run[2], m_shb[2], m_sha[2], m_bout[2], m_aout[2], m_cfg[2];
    logic [7:0] m_esrc[2];

    always #5 clk = ~clk;

    fsm_ctrl_param #(.N_FIFOS(8), .TH_W(3), .IDLE_DLY(4)) dut0 (
        .clk(clk), .reset(reset), .init(init), .bajo(bajo), .alto(alto),
        .empty_fifos(empty), .error_fifos(err),
        .estado_actual(d0_estado), .sig_estado(d0_sig),
        .bajo_out(d0_bout), .alto_out(d0_aout),
        .idle_out(d0_idle), .active_out(d0_act), .error_out(d0_errout),
        .config_err(d0_cfg), .error_src(d0_esrc)
    );

    fsm_ctrl_param #(.N_FIFOS(4), .TH_W(3), .IDLE_DLY(1)) dut1 (
        .clk(clk), .reset(reset), .init(init), .bajo(bajo), .alto(alto),
        .empty_fifos(empty[3:0]), .error_fifos(err[3:0]),
        .estado_actual(d1_estado), .sig_estado(d1_sig),
        .bajo_out(d1_bout), .alto_out(d1_aout),
        .idle_out(d1_idle), .active_out(d1_act), .error_out(d1_errout),
        .config_err(d1_cfg), .error_src(d1_esrc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fmask(input int i);
        return 8'((1 << m_nf[i]) - 1);
    endfunction

    // States: 0 reset, 1 init, 2 idle, 3 active, 4 error; m_run counts all-empty ACTIVE cycles.
    function automatic int model_next(input int i, input logic in_init,
                                      input logic [7:0] in_empty, input logic [7:0] in_err);
        logic [7:0] mk;
        bit all_e, any_e;
        mk    = fmask(i);
        all_e = ((in_empty & mk) == mk);
        any_e = ((in_err & mk) != 8'h00);
        case (m_st[i])
            0: return 1;
            1: begin
                if (in_init) return 1;
                return (m_shb[i] < m_sha[i]) ? 2 : 4;
            end
            2: begin
                if (any_e) return 4;
                if (in_init) return 1;
                return all_e ? 2 : 3;
            end
            3: begin
                if (any_e) return 4;
                if (in_init) return 1;
                return (all_e && (m_run[i] + 1 >= m_dly[i])) ? 2 : 3;
            end
            4: return in_init ? 1 : 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_update(input int i);
        int nxt;
        logic [7:0] mk;
        bit all_e;
        mk    = fmask(i);
        all_e = ((empty & mk) == mk);
        nxt   = model_next(i, init, empty, err);
        if (m_st[i] == 1 && init) begin
            m_shb[i] = int'(bajo);
            m_sha[i] = int'(alto);
        end else if (m_st[i] == 1) begin
            if (nxt == 2) begin
                m_bout[i] = m_shb[i];
                m_aout[i] = m_sha[i];
            end else begin
                m_cfg[i] = 1;
            end
        end
        if ((m_st[i] == 2 || m_st[i] == 3) && ((err & mk) != 8'h00))
            m_esrc[i] = m_esrc[i] | (err & mk);
        if (m_st[i] == 4 && init) begin
            m_esrc[i] = 8'h00;
            m_cfg[i]  = 0;
        end
        m_run[i] = (m_st[i] == 3 && nxt == 3 && all_e) ? m_run[i] + 1 : 0;
        m_st[i]  = nxt;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_run[i] = 0; m_shb[i] = 0; m_sha[i] = 0;
            m_bout[i] = 0; m_aout[i] = 0; m_cfg[i] = 0; m_esrc[i] = 8'h00;
        end
    endtask

    task automatic check_output();
        chk("d0.estado_actual", 32'(d0_estado), 32'(m_st[0]));
        chk("d0.sig_estado", 32'(d0_sig), 32'(model_next(0, init, empty, err)));
        chk("d0.bajo_out", 32'(d0_bout), 32'(m_bout[0]));
        chk("d0.alto_out", 32'(d0_aout), 32'(m_aout[0]));
        chk("d0.idle_out", 32'(d0_idle), 32'(m_st[0] == 2));
        chk("d0.active_out", 32'(d0_act), 32'(m_st[0] == 3));
        chk("d0.error_out", 32'(d0_errout), 32'(m_st[0] == 4));
        chk("d0.config_err", 32'(d0_cfg), 32'(m_cfg[0]));
        chk("d0.error_src", 32'(d0_esrc), 32'(m_esrc[0]));
        chk("d1.estado_actual", 32'(d1_estado), 32'(m_st[1]));
        chk("d1.sig_estado", 32'(d1_sig), 32'(model_next(1, init, empty, err)));
        chk("d1.bajo_out", 32'(d1_bout), 32'(m_bout[1]));
        chk("d1.alto_out", 32'(d1_aout), 32'(m_aout[1]));
        chk("d1.idle_out", 32'(d1_idle), 32'(m_st[1] == 2));
        chk("d1.active_out", 32'(d1_act), 32'(m_st[1] == 3));
        chk("d1.error_out", 32'(d1_errout), 32'(m_st[1] == 4));
        chk("d1.config_err", 32'(d1_cfg), 32'(m_cfg[1]));
        chk("d1.error_src", 32'(d1_esrc), 32'(m_esrc[1]));
    endtask

    task automatic apply_stimulus(input logic i_init, input logic [2:0] i_b, input logic [2:0] i_a,
                                  input logic [7:0] i_e, input logic [7:0] i_r);
        @(negedge clk);
        init  = i_init;
        bajo  = i_b;
        alto  = i_a;
        empty = i_e;
        err   = i_r;
        #1;
        check_output();
        @(posedge clk);
        model_update(0);
        model_update(1);
    endtask

    // Asserts reset between edges, holds it across one edge, releases just after an edge.
    task automatic reset_mid();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 model_reset();
        check_output();
        chk("rst.d0.estado", 32'(d0_estado), 32'd0);
        chk("rst.d0.bajo_out", 32'(d0_bout), 32'd0);
        chk("rst.d0.alto_out", 32'(d0_aout), 32'd0);
        chk("rst.d1.error_src", 32'(d1_esrc), 32'd0);
        @(posedge clk);
        #1 check_output();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic       ri;
        logic [2:0] rb, ra;
        logic [7:0] re, rr;

        reset = 1'b1;
        init  = 1'b0;
        bajo  = 3'd0;
        alto  = 3'd0;
        empty = 8'hFF;
        err   = 8'h00;
        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        #2 check_output();
        @(posedge clk);
        #2 reset = 1'b1;

        // Configure 2/5 and reach IDLE.
        apply_stimulus(1'b1, 3'd2, 3'd5, 8'hFF, 8'h00);
        apply_stimulus(1'b1, 3'd2, 3'd5, 8'hFF, 8'h00);
        apply_stimulus(1'b0, 3'd2, 3'd5, 8'hFF, 8'h00);
        #2;
        chk("s1.d0.estado", 32'(d0_estado), 32'd2);
        chk("s1.d0.bajo_out", 32'(d0_bout), 32'd2);
        chk("s1.d0.alto_out", 32'(d0_aout), 32'd5);
        chk("s1.d0.idle_out", 32'(d0_idle), 32'd1);
        chk("s1.d1.estado", 32'(d1_estado), 32'd2);

        // One non-empty cycle, then an all-empty run back to IDLE.
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFE, 8'h00);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
        #2 chk("s2.d0.still_active", 32'(d0_estado), 32'd3);
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
        #2 chk("s2.d0.idle_after_4", 32'(d0_estado), 32'd2);

        // Interrupted run restarts the count.
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFE, 8'h00);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFE, 8'h00);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
        #2 chk("s3.d0.still_active", 32'(d0_estado), 32'd3);
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
        #2 chk("s3.d0.idle_after_restart", 32'(d0_estado), 32'd2);

        // Error together with init: error wins and is sticky.
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFE, 8'h00);
        apply_stimulus(1'b1, 3'd0, 3'd0, 8'hFE, 8'h10);
        #2;
        chk("s4.d0.estado", 32'(d0_estado), 32'd4);
        chk("s4.d0.error_src", 32'(d0_esrc), 32'h10);
        chk("s4.d0.error_out", 32'(d0_errout), 32'd1);
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'h00, 8'hFF);
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'h3C, 8'h01);
        #2;
        chk("s4.d0.sticky", 32'(d0_estado), 32'd4);
        chk("s4.d0.error_src_held", 32'(d0_esrc), 32'h10);
        apply_stimulus(1'b1, 3'd6, 3'd3, 8'hFF, 8'h00);
        #2;
        chk("s4.d0.init", 32'(d0_estado), 32'd1);
        chk("s4.d0.error_src_clr", 32'(d0_esrc), 32'h00);

        // Rejected configuration keeps the committed thresholds.
        apply_stimulus(1'b1, 3'd6, 3'd3, 8'hFF, 8'h00);
        apply_stimulus(1'b0, 3'd6, 3'd3, 8'hFF, 8'h00);
        #2;
        chk("s5.d0.estado", 32'(d0_estado), 32'd4);
        chk("s5.d0.config_err", 32'(d0_cfg), 32'd1);
        chk("s5.d0.bajo_kept", 32'(d0_bout), 32'd2);
        chk("s5.d0.alto_kept", 32'(d0_aout), 32'd5);
        apply_stimulus(1'b1, 3'd1, 3'd6, 8'hFF, 8'h00);
        apply_stimulus(1'b1, 3'd1, 3'd6, 8'hFF, 8'h00);
        apply_stimulus(1'b0, 3'd1, 3'd6, 8'hFF, 8'h00);
        #2 chk("s5.d0.bajo_new", 32'(d0_bout), 32'd1);

        // Asynchronous reset while ACTIVE, then reconfigure.
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFE, 8'h00);
        reset_mid();
        apply_stimulus(1'b1, 3'd3, 3'd4, 8'hFF, 8'h00);
        apply_stimulus(1'b1, 3'd3, 3'd4, 8'hFF, 8'h00);
        apply_stimulus(1'b0, 3'd3, 3'd4, 8'hFF, 8'h00);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_mid();
            end else begin
                ri = ($urandom_range(0, 7) == 0);
                rb = 3'($urandom);
                ra = 3'($urandom);
                re = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                rr = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
                apply_stimulus(ri, rb, ra, re, rr);
            end
        end
        apply_stimulus(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_ctrl_param.md
FSM_CTRL_PARAM -- requirements
Module: fsm_ctrl_param

Interface
REQ-001 SHALL have parameter N_FIFOS, default 8, the number of monitored FIFOs (range 1..32).
REQ-002 SHALL have parameter TH_W, default 3, the width of each threshold.
REQ-003 SHALL have parameter IDLE_DLY, default 4, the number of consecutive all-empty cycles in ACTIVE that are required before moving to IDLE (range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port init, input, 1 bit: configuration request.
REQ-007 SHALL have port bajo, input, TH_W bits: the requested low threshold.
REQ-008 SHALL have port alto, input, TH_W bits: the requested high threshold.
REQ-009 SHALL have port empty_fifos, input, N_FIFOS bits: per-FIFO empty flags.
REQ-010 SHALL have port error_fifos, input, N_FIFOS bits: per-FIFO overflow/underflow flags.
REQ-011 SHALL have port estado_actual, output, 3 bits: the registered current state.
REQ-012 SHALL have port sig_estado, output, 3 bits: the combinational next state.
REQ-013 SHALL have port bajo_out, output, TH_W bits: the committed low threshold (registered).
REQ-014 SHALL have port alto_out, output, TH_W bits: the committed high threshold (registered).
REQ-015 SHALL have ports idle_out, active_out and error_out, each an output of 1 bit: registered, with exactly one high in IDLE, ACTIVE and ERROR respectively.
REQ-016 SHALL have port config_err, output, 1 bit: registered; set when a rejected configuration causes entry to ERROR.
REQ-017 SHALL have port error_src, output, N_FIFOS bits: the registered sticky OR of error_fifos, captured while in IDLE or ACTIVE.

Function
REQ-018 SHALL encode the states as RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; any other code SHALL go to RESET on the next cycle.
REQ-019 SHALL leave RESET for INIT on the first clock edge after reset deasserts.
REQ-020 SHALL, while in INIT with init=1, capture bajo and alto into shadow registers every cycle; bajo_out and alto_out SHALL hold their values.
REQ-021 SHALL, in INIT with init=0, move to IDLE when shadow_bajo < shadow_alto, committing the shadow values to bajo_out and alto_out on the same edge.
REQ-022 SHALL, in INIT with init=0 and shadow_bajo >= shadow_alto (unsigned compare), move to ERROR, set config_err=1 and leave bajo_out and alto_out unchanged.
REQ-023 SHALL apply this transition priority in IDLE and ACTIVE: any error_fifos bit high -> ERROR; else init=1 -> INIT; else the empty-based rule.
REQ-024 SHALL, in IDLE, stay in IDLE when empty_fifos is all ones, otherwise move to ACTIVE on the next edge.
REQ-025 SHALL keep an empty-run counter in ACTIVE: increment when empty_fifos is all ones, clear to 0 otherwise; move to IDLE when the counter reaches IDLE_DLY-1 and empty_fifos is still all ones, i.e. after exactly IDLE_DLY all-empty cycles.
REQ-026 SHALL size the counter to ceil(log2(IDLE_DLY+1)) bits, saturating and never wrapping.
REQ-027 SHALL clear the counter on every transition out of ACTIVE.
REQ-028 SHALL OR error_fifos into error_src in every IDLE or ACTIVE cycle that has any error bit high, including the cycle that causes the ERROR transition.
REQ-029 SHALL make ERROR sticky: error_fifos and empty_fifos are ignored there, and only init=1 leaves it, moving to INIT.
REQ-030 SHALL clear error_src and config_err on the INIT entry that follows ERROR.
REQ-031 SHALL register idle_out, active_out and error_out from sig_estado, so that they match estado_actual in the same cycle.
REQ-032 SHALL make sig_estado purely combinational from estado_actual and the inputs, with no latches and every branch assigned.

Reset
REQ-033 SHALL, while reset=0, asynchronously force estado_actual=RESET, all flags 0, bajo_out=0, alto_out=0, error_src=0, shadows 0 and counter 0.
REQ-034 SHALL, when reset is asserted mid-operation in any state, abort immediately and discard the shadows; the committed thresholds SHALL return to 0.
REQ-035 SHALL require no synchronous reset path.

Verification
REQ-036 Scenario: reset released; init=1 with bajo=2, alto=5; then init=0 -> states RESET, INIT, IDLE; bajo_out=2 and alto_out=5 in the first IDLE cycle; idle_out=1.
REQ-037 Scenario: in IDLE, empty_fifos=8'hFE for 1 cycle, then 8'hFF -> ACTIVE on the next edge; IDLE returns exactly 4 cycles after the all-empty condition begins (IDLE_DLY=4).
REQ-038 Scenario: in ACTIVE, an all-empty run of 3 cycles, then one non-empty cycle, then all-empty -> counter restarts; IDLE 4 cycles after the restart.
REQ-039 Scenario: in ACTIVE, error_fifos=8'h10 asserted together with init=1 -> ERROR (error wins); error_src=8'h10; error_out=1; later inputs are ignored until init=1 -> INIT with error_src=0.
REQ-040 Scenario: INIT with bajo=6, alto=3, init falls -> ERROR with config_err=1; bajo_out and alto_out keep their previous committed values.
REQ-041 Scenario: reset asserted between clock edges while in ACTIVE -> estado_actual=RESET and all outputs 0 before the next rising edge; repeat the full suite with N_FIFOS=4 and IDLE_DLY=1.
